spi_master: RTL

//  SPI initiator that pairs with the team's SPI slave. One DATA_WIDTH-bit full-duplex transfer per start.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_clk_gen.sv | 31 +++
 rtl/spi_master.sv | 119 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI initiator and its clock generator.
package spi_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT    = 3'd2,
    HOLD     = 3'd3,
    REARM_HI = 3'd4,
    REARM_LO = 3'd5
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: counts 0..HALF_PERIOD-1 while enabled, ticks on wrap.
module spi_clk_gen #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  // Keep at least one counter bit so HALF_PERIOD=1 still elaborates; the compare is then always true.
  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI initiator: one full-duplex DATA_WIDTH-bit transfer per accepted start, MSB first,
// followed by a single SCLK pulse with CS high to re-arm the slave's bit counter.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int HALF_PERIOD = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] masterDataToSend,
  output logic [DATA_WIDTH-1:0] masterDataReceived,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic                  CS,
  output logic                  MOSI,
  input  logic                  MISO,
  output spi_state_e            state
);

  // Handshake: start is a level sampled only while state==IDLE; busy rises the cycle
  // after acceptance and falls in the same cycle done pulses for one clk.

  localparam int EW = $clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

  logic                  tick;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] rx;
  logic [EW-1:0]         edge_cnt;

  spi_clk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clk_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      CS                 <= 1'b1;
      SCLK               <= 1'b0;
      MOSI               <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      masterDataReceived <= '0;
      shreg              <= '0;
      rx                 <= '0;
      edge_cnt           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= masterDataToSend;
            CS       <= 1'b0;
            busy     <= 1'b1;
            edge_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            edge_cnt <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            // Even edges rise and launch the next bit; odd edges fall and capture MISO.
            if (!edge_cnt[0]) begin
              SCLK  <= 1'b1;
              MOSI  <= shreg[DATA_WIDTH-1];
              shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
            end else begin
              SCLK <= 1'b0;
              rx   <= {rx[DATA_WIDTH-2:0], MISO};
            end
            if (edge_cnt == LAST_EDGE) begin
              edge_cnt <= '0;
              state    <= HOLD;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            CS    <= 1'b1;
            MOSI  <= 1'b0;
            state <= REARM_HI;
          end
        end
        REARM_HI: begin
          if (tick) begin
            SCLK  <= 1'b1;
            state <= REARM_LO;
          end
        end
        REARM_LO: begin
          if (tick) begin
            SCLK               <= 1'b0;
            masterDataReceived <= rx;
            done               <= 1'b1;
            busy               <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
